// File: rtl/song_feeder.sv
// Streams a song from a synchronous note ROM into three lane windows (red, yellow, blue).
// Bit WINDOW-1 of each window holds the note currently at the hit line.
module song_feeder #(
    parameter int unsigned WINDOW   = 26,
    parameter int unsigned SONG_LEN = 100,
    parameter int unsigned ADDR_W   = 7
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    input  logic                step,
    output logic [ADDR_W-1:0]   rom_addr,
    input  logic [2:0]          rom_data,
    output logic [WINDOW-1:0]   out_red,
    output logic [WINDOW-1:0]   out_yellow,
    output logic [WINDOW-1:0]   out_blue,
    output logic                playing,
    output logic                song_done,
    output logic [ADDR_W+4:0]   step_count
);

    localparam int unsigned NOTE_W  = $clog2(SONG_LEN + 1);
    localparam int unsigned DRAIN_W = $clog2(WINDOW + 1);
    localparam int unsigned CNT_W   = ADDR_W + 5;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        WAIT,
        READY,
        DRAIN
    } state_t;

    state_t              state, state_next;
    logic [ADDR_W-1:0]   rom_addr_next;
    logic [2:0]          nxt, nxt_next;
    logic                pending, pending_next;
    logic [NOTE_W-1:0]   note_cnt, note_cnt_next;
    logic [DRAIN_W-1:0]  drain_cnt, drain_cnt_next;
    logic [WINDOW-1:0]   red_next, yellow_next, blue_next;
    logic                playing_next, song_done_next;
    logic [CNT_W-1:0]    step_count_next;
    logic [CNT_W-1:0]    step_count_inc;

    // Debug step counter sticks at all-ones instead of wrapping.
    assign step_count_inc = (step_count == '1) ? step_count : step_count + CNT_W'(1);

    // State and datapath registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            rom_addr   <= '0;
            nxt        <= '0;
            pending    <= 1'b0;
            note_cnt   <= '0;
            drain_cnt  <= '0;
            out_red    <= '0;
            out_yellow <= '0;
            out_blue   <= '0;
            playing    <= 1'b0;
            song_done  <= 1'b0;
            step_count <= '0;
        end else begin
            state      <= state_next;
            rom_addr   <= rom_addr_next;
            nxt        <= nxt_next;
            pending    <= pending_next;
            note_cnt   <= note_cnt_next;
            drain_cnt  <= drain_cnt_next;
            out_red    <= red_next;
            out_yellow <= yellow_next;
            out_blue   <= blue_next;
            playing    <= playing_next;
            song_done  <= song_done_next;
            step_count <= step_count_next;
        end
    end

    // Next-state and datapath logic.
    always_comb begin
        state_next      = state;
        rom_addr_next   = rom_addr;
        nxt_next        = nxt;
        pending_next    = pending;
        note_cnt_next   = note_cnt;
        drain_cnt_next  = drain_cnt;
        red_next        = out_red;
        yellow_next     = out_yellow;
        blue_next       = out_blue;
        playing_next    = playing;
        song_done_next  = 1'b0;
        step_count_next = step_count;

        case (state)
            IDLE: begin
                if (start) begin
                    state_next      = ADDR;
                    rom_addr_next   = '0;
                    note_cnt_next   = '0;
                    drain_cnt_next  = '0;
                    pending_next    = 1'b0;
                    playing_next    = 1'b1;
                    step_count_next = '0;
                    red_next        = '0;
                    yellow_next     = '0;
                    blue_next       = '0;
                end
            end

            ADDR: begin
                state_next = WAIT;
                if (step) pending_next = 1'b1;
            end

            WAIT: begin
                nxt_next   = rom_data;
                state_next = READY;
                if (step) pending_next = 1'b1;
            end

            READY: begin
                // A step held over from ADDR/WAIT is served here; a concurrent new step merges with it.
                if (step || pending) begin
                    red_next        = {out_red[WINDOW-2:0], nxt[2]};
                    yellow_next     = {out_yellow[WINDOW-2:0], nxt[1]};
                    blue_next       = {out_blue[WINDOW-2:0], nxt[0]};
                    step_count_next = step_count_inc;
                    pending_next    = 1'b0;
                    note_cnt_next   = note_cnt + NOTE_W'(1);
                    if (note_cnt == NOTE_W'(SONG_LEN - 1)) begin
                        state_next = DRAIN;
                    end else begin
                        rom_addr_next = rom_addr + ADDR_W'(1);
                        state_next    = ADDR;
                    end
                end
            end

            DRAIN: begin
                if (step) begin
                    red_next        = {out_red[WINDOW-2:0], 1'b0};
                    yellow_next     = {out_yellow[WINDOW-2:0], 1'b0};
                    blue_next       = {out_blue[WINDOW-2:0], 1'b0};
                    step_count_next = step_count_inc;
                    if (drain_cnt == DRAIN_W'(WINDOW - 1)) begin
                        drain_cnt_next = '0;
                        song_done_next = 1'b1;
                        playing_next   = 1'b0;
                        state_next     = IDLE;
                    end else begin
                        drain_cnt_next = drain_cnt + DRAIN_W'(1);
                    end
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_song_feeder.sv
// Self-checking bench for song_feeder: randomized songs compared against a window model
// derived from note addresses (note k sits at window bit s-1-k after s steps).
module tb_song_feeder;

    localparam int unsigned WINDOW   = 26;
    localparam int unsigned SONG_LEN = 100;
    localparam int unsigned ADDR_W   = 7;
    localparam int          TOTAL    = 126;

    logic                clock = 1'b0;
    logic                reset;
    logic                start;
    logic                step;
    logic [ADDR_W-1:0]   rom_addr;
    logic [2:0]          rom_data;
    logic [WINDOW-1:0]   out_red, out_yellow, out_blue;
    logic                playing;
    logic                song_done;
    logic [ADDR_W+4:0]   step_count;

    logic [2:0] rom_mem [0:SONG_LEN-1];
    int checks   = 0;
    int failures = 0;
    int done_cnt = 0;

    song_feeder #(.WINDOW(WINDOW), .SONG_LEN(SONG_LEN), .ADDR_W(ADDR_W)) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .step       (step),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .out_red    (out_red),
        .out_yellow (out_yellow),
        .out_blue   (out_blue),
        .playing    (playing),
        .song_done  (song_done),
        .step_count (step_count)
    );

    always #5 clock = ~clock;

    // Synchronous ROM: data valid one cycle after the address.
    always @(posedge clock)
        rom_data <= (rom_addr < 7'd100) ? rom_mem[rom_addr] : 3'b000;

    always @(negedge clock)
        if (song_done === 1'b1) done_cnt++;

    // Expected lane window after s applied steps; b selects 2=red 1=yellow 0=blue.
    function automatic logic [25:0] exp_lane(input int s, input int b);
        logic [25:0] w;
        logic [2:0]  n;
        w = '0;
        for (int i = 0; i < 26; i++) begin
            int a;
            a = s - 1 - i;
            if (a >= 0 && a < 100) begin
                n = rom_mem[a];
                w[i] = n[b];
            end
        end
        return w;
    endfunction

    task automatic load_rom(input int mode);
        for (int a = 0; a < 100; a++) begin
            if (mode == 1)      rom_mem[a] = 3'b111;
            else if (mode == 2) rom_mem[a] = (a == 0) ? 3'b100 : 3'b000;
            else                rom_mem[a] = 3'($urandom_range(0, 7));
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        start = 1'b0;
        step  = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
    endtask

    // Pulse tasks start and end on a falling edge.
    task automatic pulse_start();
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic pulse_step();
        step = 1'b1;
        @(negedge clock);
        step = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        step  = 1'b0;
        repeat (2) @(negedge clock);
        checks++;
        if (out_red !== '0 || out_yellow !== '0 || out_blue !== '0) begin
            failures++;
            $display("FAIL reset_windows got %h %h %h want 0", out_red, out_yellow, out_blue);
        end
        checks++;
        if (rom_addr !== '0) begin failures++; $display("FAIL reset_addr got %0d want 0", rom_addr); end
        checks++;
        if (playing !== 1'b0 || song_done !== 1'b0) begin
            failures++;
            $display("FAIL reset_flags playing=%b done=%b want 0 0", playing, song_done);
        end
        checks++;
        if (step_count !== '0) begin failures++; $display("FAIL reset_count got %0d want 0", step_count); end
        reset = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_idle_steps();
        do_reset();
        load_rom(0);
        for (int k = 0; k < 4; k++) begin
            pulse_step();
            repeat (2) @(negedge clock);
        end
        checks++;
        if (out_red !== '0 || out_yellow !== '0 || out_blue !== '0 || step_count !== '0 || playing !== 1'b0) begin
            failures++;
            $display("FAIL idle_steps win=%h %h %h cnt=%0d playing=%b want 0", out_red, out_yellow, out_blue, step_count, playing);
        end
        start = 1'b1;
        step  = 1'b1;
        @(negedge clock);
        start = 1'b0;
        step  = 1'b0;
        checks++;
        if (playing !== 1'b1 || step_count !== '0) begin
            failures++;
            $display("FAIL start_step_same playing=%b cnt=%0d want 1 0", playing, step_count);
        end
        repeat (5) @(negedge clock);
        checks++;
        if (step_count !== '0 || out_red !== '0) begin
            failures++;
            $display("FAIL start_step_no_shift cnt=%0d red=%h want 0 0", step_count, out_red);
        end
    endtask

    task automatic test_single_note();
        logic exp_hit;
        do_reset();
        load_rom(2);
        pulse_start();
        repeat (3) @(negedge clock);
        for (int s = 1; s <= 27; s++) begin
            pulse_step();
            exp_hit = (s == 26);
            checks++;
            if (out_red[25] !== exp_hit) begin
                failures++;
                $display("FAIL single_red_hit step=%0d got %b want %b", s, out_red[25], exp_hit);
            end
            checks++;
            if (out_yellow !== '0 || out_blue !== '0) begin
                failures++;
                $display("FAIL single_other_lanes step=%0d got %h %h want 0 0", s, out_yellow, out_blue);
            end
            repeat (3) @(negedge clock);
        end
    endtask

    task automatic test_full_song(input int mode, input int gmin, input int gmax);
        int base;
        int gap;
        logic [25:0] er, ey, eb;
        logic exp_play, exp_done;
        do_reset();
        load_rom(mode);
        base = done_cnt;
        pulse_start();
        repeat (3) @(negedge clock);
        for (int s = 1; s <= TOTAL; s++) begin
            pulse_step();
            er = exp_lane(s, 2);
            ey = exp_lane(s, 1);
            eb = exp_lane(s, 0);
            exp_play = (s < TOTAL);
            exp_done = (s == TOTAL);
            checks++;
            if (out_red !== er || out_yellow !== ey || out_blue !== eb) begin
                failures++;
                $display("FAIL song_windows step=%0d got %h %h %h want %h %h %h", s, out_red, out_yellow, out_blue, er, ey, eb);
            end
            checks++;
            if (step_count !== 12'(s)) begin
                failures++;
                $display("FAIL song_count step=%0d got %0d want %0d", s, step_count, s);
            end
            if (s < 100) begin
                checks++;
                if (rom_addr !== 7'(s)) begin
                    failures++;
                    $display("FAIL song_addr step=%0d got %0d want %0d", s, rom_addr, s);
                end
            end
            checks++;
            if (playing !== exp_play || song_done !== exp_done) begin
                failures++;
                $display("FAIL song_flags step=%0d playing=%b done=%b want %b %b", s, playing, song_done, exp_play, exp_done);
            end
            if (mode == 1 && s == 26) begin
                checks++;
                if (out_red !== 26'h3FFFFFF || out_yellow !== 26'h3FFFFFF || out_blue !== 26'h3FFFFFF) begin
                    failures++;
                    $display("FAIL all_ones_full got %h %h %h want 3ffffff", out_red, out_yellow, out_blue);
                end
            end
            gap = $urandom_range(gmin, gmax);
            repeat (gap - 1) @(negedge clock);
        end
        repeat (4) @(negedge clock);
        checks++;
        if (done_cnt - base !== 1) begin
            failures++;
            $display("FAIL done_once pulses got %0d want 1", done_cnt - base);
        end
        checks++;
        if (song_done !== 1'b0 || playing !== 1'b0 || out_red !== '0 || out_yellow !== '0 || out_blue !== '0) begin
            failures++;
            $display("FAIL after_done done=%b playing=%b win=%h %h %h want 0", song_done, playing, out_red, out_yellow, out_blue);
        end
    endtask

    task automatic test_pending();
        logic [25:0] er, ey, eb;
        do_reset();
        load_rom(0);
        pulse_start();
        pulse_step();
        pulse_step();
        checks++;
        if (step_count !== '0) begin
            failures++;
            $display("FAIL pending_early cnt=%0d want 0", step_count);
        end
        @(negedge clock);
        er = exp_lane(1, 2);
        ey = exp_lane(1, 1);
        eb = exp_lane(1, 0);
        checks++;
        if (step_count !== 12'd1 || out_red !== er || out_yellow !== ey || out_blue !== eb) begin
            failures++;
            $display("FAIL pending_shift cnt=%0d win=%h %h %h want 1 %h %h %h", step_count, out_red, out_yellow, out_blue, er, ey, eb);
        end
        repeat (6) @(negedge clock);
        checks++;
        if (step_count !== 12'd1) begin
            failures++;
            $display("FAIL pending_drop cnt=%0d want 1", step_count);
        end
    endtask

    task automatic test_restart();
        do_reset();
        load_rom(0);
        pulse_start();
        repeat (3) @(negedge clock);
        for (int s = 1; s <= 40; s++) begin
            pulse_step();
            repeat (3) @(negedge clock);
        end
        checks++;
        if (rom_addr !== 7'd40) begin failures++; $display("FAIL restart_addr40 got %0d want 40", rom_addr); end
        pulse_start();
        repeat (3) @(negedge clock);
        checks++;
        if (playing !== 1'b1 || step_count !== 12'd40 || rom_addr !== 7'd40) begin
            failures++;
            $display("FAIL restart_ignored playing=%b cnt=%0d addr=%0d want 1 40 40", playing, step_count, rom_addr);
        end
        pulse_step();
        checks++;
        if (rom_addr !== 7'd41 || step_count !== 12'd41 || out_blue !== exp_lane(41, 0)) begin
            failures++;
            $display("FAIL restart_continue addr=%0d cnt=%0d blue=%h want 41 41 %h", rom_addr, step_count, out_blue, exp_lane(41, 0));
        end
    endtask

    task automatic test_reset_drain();
        int base;
        do_reset();
        load_rom(1);
        pulse_start();
        repeat (3) @(negedge clock);
        for (int s = 1; s <= 110; s++) begin
            pulse_step();
            repeat (2) @(negedge clock);
        end
        base = done_cnt;
        reset = 1'b1;
        @(negedge clock);
        checks++;
        if (out_red !== '0 || out_yellow !== '0 || out_blue !== '0 || playing !== 1'b0 || step_count !== '0) begin
            failures++;
            $display("FAIL drain_reset win=%h %h %h playing=%b cnt=%0d want 0", out_red, out_yellow, out_blue, playing, step_count);
        end
        reset = 1'b0;
        @(negedge clock);
        for (int k = 0; k < 20; k++) begin
            pulse_step();
            repeat (2) @(negedge clock);
        end
        checks++;
        if (done_cnt !== base || out_red !== '0 || playing !== 1'b0) begin
            failures++;
            $display("FAIL drain_no_done pulses=%0d red=%h playing=%b want 0 0 0", done_cnt - base, out_red, playing);
        end
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        step  = 1'b0;
        test_reset();
        test_idle_steps();
        test_single_note();
        test_full_song(1, 10, 10);
        test_full_song(0, 3, 8);
        test_pending();
        test_restart();
        test_reset_drain();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
